// File: rtl/led_fade_pwm.sv
// PWM output stage for the LED chaser: lit channels run at global_duty, released channels fade linearly to dark.
// Optional macro LED_FADE_GAMMA_EN selects a quadratic brightness curve (one extra pipeline stage on eff).
module led_fade_pwm #(
    parameter int CH       = 8,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [CH-1:0]       led_in,
    input  logic [PWM_BITS-1:0] global_duty,
    output logic [CH-1:0]       led_out,
    output logic                busy
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                pwm_wrap;
    logic                fade_tick;
    logic [PWM_BITS-1:0] level [CH];
    logic [PWM_BITS-1:0] eff   [CH];
    logic [CH-1:0]       out_next;
    logic                busy_next;

    assign pwm_wrap  = (pwm_cnt == PWM_MAX);
    assign fade_tick = pwm_wrap && (div_cnt == DIV_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_wrap) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
        end
    end

    // A lit channel tracks global_duty every clock; that load outranks a coincident fade step.
    always_ff @(posedge sys_clk) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (sys_rst) begin
                level[i] <= '0;
            end else if (led_in[i]) begin
                level[i] <= global_duty;
            end else if (fade_tick && level[i] != '0) begin
                level[i] <= level[i] - PWM_BITS'(1);
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod [CH];

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            prod[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (sys_rst) begin
                eff[i] <= '0;
            end else begin
                eff[i] <= PWM_BITS'(prod[i] >> PWM_BITS);
            end
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            eff[i] = level[i];
        end
    end
`endif

    always_comb begin
        out_next  = '0;
        busy_next = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            out_next[i] = (eff[i] > pwm_cnt);
            if (level[i] != '0 && !led_in[i]) begin
                busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            led_out <= out_next;
            busy    <= busy_next;
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: per-cycle reference model plus duty-count and fade-time checks.
module tb_led_fade_pwm;

    localparam int CH = 8;
    localparam int PB = 8;
    localparam int FD = 2;
    localparam int P  = 256;
`ifdef LED_FADE_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [CH-1:0] led_in = '0;
    logic [PB-1:0] global_duty = '0;
    logic [CH-1:0] led_out;
    logic          busy;

    led_fade_pwm #(.CH(CH), .PWM_BITS(PB), .FADE_DIV(FD)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .led_in      (led_in),
        .global_duty (global_duty),
        .led_out     (led_out),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: elapsed clocks since reset, brightness per channel, gamma stage
    int            cyc = 0;
    int            lvl  [CH];
    int            effq [CH];
    logic [CH-1:0] m_out = '0;
    logic          m_busy = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bright(input int d);
        return GAMMA ? (d * d) / P : d;
    endfunction

    function automatic bit tick_next();
        return (cyc % (P * FD)) == (P * FD - 1);
    endfunction

    task automatic model_step(input logic r, input logic [CH-1:0] li, input int gd);
        int            nl [CH];
        int            ne [CH];
        logic [CH-1:0] no;
        logic          nb;
        int            ph;
        bit            tk;
        if (r) begin
            cyc = 0;
            for (int i = 0; i < CH; i++) begin lvl[i] = 0; effq[i] = 0; end
            m_out  = '0;
            m_busy = 1'b0;
            return;
        end
        ph = cyc % P;
        tk = tick_next();
        nb = 1'b0;
        for (int i = 0; i < CH; i++) begin
            no[i] = ((GAMMA ? effq[i] : lvl[i]) > ph);
            if (lvl[i] != 0 && !li[i]) nb = 1'b1;
            if (li[i])                 nl[i] = gd;
            else if (tk && lvl[i] > 0) nl[i] = lvl[i] - 1;
            else                       nl[i] = lvl[i];
            ne[i] = (lvl[i] * lvl[i]) / P;
        end
        for (int i = 0; i < CH; i++) begin lvl[i] = nl[i]; effq[i] = ne[i]; end
        m_out  = no;
        m_busy = nb;
        cyc++;
    endtask

    task automatic step(input logic r, input logic [CH-1:0] li, input int gd);
        sys_rst     = r;
        led_in      = li;
        global_duty = PB'(gd);
        model_step(r, li, gd);
        @(posedge sys_clk);
        #1;
        check("led_out", int'(led_out), int'(m_out));
        check("busy", int'(busy), int'(m_busy));
    endtask

    // settles, then counts ch0 high clocks over 4 whole periods
    task automatic duty_run(input int gd, input string tag);
        int ones = 0, others = 0, bz = 0;
        for (int k = 0; k < 4; k++) step(1'b0, 8'h01, gd);
        for (int k = 0; k < 4 * P; k++) begin
            step(1'b0, 8'h01, gd);
            ones   += int'(led_out[0]);
            others += int'(|led_out[CH-1:1]);
            bz     += int'(busy);
        end
        check({tag, "_high"}, ones, 4 * bright(gd));
        check({tag, "_others"}, others, 0);
        check({tag, "_busy"}, bz, 0);
    endtask

    initial begin
        int n;
        int budget;
        int duty;
        logic [CH-1:0] pat;

        for (int k = 0; k < 3; k++) step(1'b1, 8'hFF, 200);
        check("rst_led_out", int'(led_out), 0);
        check("rst_busy", int'(busy), 0);

        duty_run(128, "duty128");
        duty_run(0,   "duty0");
        duty_run(255, "duty255");

        // linear fade from level 40 to dark
        for (int k = 0; k < 8; k++) step(1'b0, 8'h01, 40);
        step(1'b0, 8'h00, 40);
        check("busy_rise", int'(busy), 1);
        budget = 41 * FD * P + 8;
        n = 1;
        while (busy && n < budget) begin step(1'b0, 8'h00, 40); n++; end
        check("fade_timeout", int'(n < budget), 1);
        check("fade_len", int'(n >= 39 * FD * P + 2 && n <= 40 * FD * P + 1), 1);
        for (int k = 0; k < 2 * P; k++) step(1'b0, 8'h00, 40);
        check("dark_after_fade", int'(led_out[0]), 0);

        // relight exactly on the fade tick that would take level 41 -> 40
        for (int k = 0; k < 4; k++) step(1'b0, 8'h01, 45);
        n = 0;
        while (!(lvl[0] == 41 && tick_next()) && n < 8 * FD * P) begin
            step(1'b0, 8'h00, 45); n++;
        end
        check("tick_align_timeout", int'(n < 8 * FD * P), 1);
        step(1'b0, 8'h01, 128);
        duty_run(128, "relight");

        // reset in the middle of a fade
        for (int k = 0; k < 300; k++) step(1'b0, 8'h00, 0);
        check("midfade_busy", int'(busy), 1);
        step(1'b1, 8'h00, 0);
        check("midfade_rst_out", int'(led_out), 0);
        check("midfade_rst_busy", int'(busy), 0);
        step(1'b0, 8'h00, 0);

        // walking chaser pattern, each released channel fades on its own
        duty = $urandom_range(24, 8);
        for (int s = 0; s < CH; s++) begin
            pat = '0;
            pat[s] = 1'b1;
            for (int k = 0; k < 2 * P; k++) step(1'b0, pat, duty);
        end
        n = 0;
        while (busy && n < (duty + 2) * FD * P) begin step(1'b0, 8'h00, duty); n++; end
        check("chaser_tail_timeout", int'(busy), 0);

        // random segments: patterns, duties, occasional reset
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(15, 0) == 0) begin
                for (int k = 0; k < int'($urandom_range(3, 1)); k++) step(1'b1, CH'($urandom), 0);
            end else begin
                pat  = CH'($urandom);
                duty = $urandom_range(255, 0);
                n    = $urandom_range(300, 1);
                for (int k = 0; k < n; k++) step(1'b0, pat, duty);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
